// File: rtl/dff_trio.sv
// rtl/dff_trio.sv - three parallel D registers with no / synchronous / masked-synchronous reset; optional clock enable under DFF_TRIO_CE_EN
module dff_trio #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
`ifdef DFF_TRIO_CE_EN
  input  logic             ce,
`endif
  output logic [WIDTH-1:0] q_nrst,
  output logic [WIDTH-1:0] q_sync,
  output logic [WIDTH-1:0] q_async
);

  logic             load;
  logic [WIDTH-1:0] r_async;

`ifdef DFF_TRIO_CE_EN
  assign load = ce;
`else
  assign load = 1'b1;
`endif

  // Resetless capture: power-up contents stay unknown until the first load
  always_ff @(posedge clk) begin
    if (load) begin
      q_nrst <= d;
    end
  end

  // Synchronous reset wins over the load enable
  always_ff @(posedge clk) begin
    if (reset) begin
      q_sync <= RESET_VAL;
    end else if (load) begin
      q_sync <= d;
    end
  end

  // Backing register for q_async, same update rule as q_sync
  always_ff @(posedge clk) begin
    if (reset) begin
      r_async <= RESET_VAL;
    end else if (load) begin
      r_async <= d;
    end
  end

  // Reset masks the output at once, without waiting for an edge
  assign q_async = reset ? RESET_VAL : r_async;

endmodule

// File: tb/tb_dff_trio.sv
// tb/tb_dff_trio.sv - randomized scoreboard bench for dff_trio
module tb_dff_trio;

  localparam int unsigned      W  = 8;
  localparam logic [W-1:0]     RV = 8'hA5;
  localparam int               N_CYC = 300;

  logic         clk;
  logic         reset;
  logic [W-1:0] d;
  logic [W-1:0] q_nrst, q_sync, q_async;
`ifdef DFF_TRIO_CE_EN
  logic         ce;
`endif

  dff_trio #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
`ifdef DFF_TRIO_CE_EN
    .ce      (ce),
`endif
    .q_nrst  (q_nrst),
    .q_sync  (q_sync),
    .q_async (q_async)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] nrst;
    logic [W-1:0] sync;
    logic [W-1:0] asyn;
    bit           chk_nrst;
    bit           chk_sync;
    bit           chk_asyn;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state: what each output ought to hold according to the rules
  logic [W-1:0] m_nrst, m_sync;
  bit           m_nrst_known = 0;
  bit           m_sync_known = 0;
  bit           ce_now = 1;

  task automatic push_expect();
    exp_t e;
    e.nrst     = m_nrst;
    e.sync     = m_sync;
    e.asyn     = reset ? RV : m_sync;
    e.chk_nrst = m_nrst_known;
    e.chk_sync = m_sync_known;
    e.chk_asyn = reset || m_sync_known;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
  endtask

  task automatic check_now();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_empty t=%0t got=0 entries want>=1", $time);
    end else begin
      e = exp_q.pop_front();
      if (e.chk_nrst) cmp("q_nrst",  q_nrst,  e.nrst);
      if (e.chk_sync) cmp("q_sync",  q_sync,  e.sync);
      if (e.chk_asyn) cmp("q_async", q_async, e.asyn);
    end
  endtask

  // Monitor: samples 2 ns after every clock transition, independent of the driver
  initial begin
    #2;
    check_now();
    forever begin
      @(posedge clk or negedge clk);
      #2;
      check_now();
    end
  end

  // Driver plus reference model
  initial begin
    bit           pulse;
    logic         nxt_reset;
    logic [W-1:0] nxt_d;
    bit           nxt_ce;
    reset = 1'b1;
    d     = '0;
`ifdef DFF_TRIO_CE_EN
    ce    = 1'b1;
`endif
    ce_now = 1;
    push_expect();
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      if (ce_now) begin
        m_nrst = d;
        m_nrst_known = 1;
      end
      if (reset) begin
        m_sync = RV;
        m_sync_known = 1;
      end else if (ce_now) begin
        m_sync = d;
      end
      #1;
      push_expect();

      @(negedge clk);
      pulse  = 0;
      nxt_ce = 1;
      case (cyc)
        0: begin nxt_reset = 0; nxt_d = 8'h01; end
        1: begin nxt_reset = 1; nxt_d = 8'h01; end
        2: begin nxt_reset = 1; nxt_d = 8'h01; end
        3: begin nxt_reset = 0; nxt_d = 8'hFF; end
        4: begin nxt_reset = 0; nxt_d = 8'hFF; end
        5: begin nxt_reset = 0; nxt_d = 8'hFF; pulse = 1; end
        6: begin nxt_reset = 0; nxt_d = 8'h3C; end
        default: begin
          nxt_reset = ($urandom_range(0, 5) == 0);
          pulse     = !nxt_reset && ($urandom_range(0, 5) == 0);
          nxt_d     = W'($urandom);
`ifdef DFF_TRIO_CE_EN
          nxt_ce    = ($urandom_range(0, 3) != 0);
`endif
        end
      endcase
      reset = nxt_reset;
      d     = nxt_d;
`ifdef DFF_TRIO_CE_EN
      ce    = nxt_ce;
`endif
      ce_now = nxt_ce;
      if (pulse) begin
        #1 reset = 1'b1;
        push_expect();
        #2 reset = 1'b0;
      end else begin
        push_expect();
      end
    end
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
